// File: rtl/frame_serializer.sv
// Captures a frame on frame_load and streams it LSB byte first, then seq, then checksum; byte 0 valid the cycle after capture.
// Valid/ready output: tx_valid/tx_data hold until accepted; a second frame waits in a one-deep pending buffer, a third is dropped with overrun.
module frame_serializer #(
    parameter int PAYLOAD_BYTES = 66
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*PAYLOAD_BYTES-1:0] frame_in,
    input  logic                       frame_load,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       overrun
);

    localparam int         FW       = 8 * PAYLOAD_BYTES;
    localparam logic [6:0] LAST_IDX = 7'(PAYLOAD_BYTES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_SEQ     = 2'd2;
    localparam logic [1:0] S_CSUM    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [6:0]    idx_q, idx_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    acc_q, acc_d;
    logic [FW-1:0] active_q, active_d;
    logic [FW-1:0] pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;
    logic          xfer;
    logic          csum_done;

    assign xfer = tx_valid_q && tx_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        acc_d      = acc_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        overrun_d  = 1'b0;
        csum_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_load) begin
                    active_d = frame_in;
                    idx_d    = '0;
                    acc_d    = '0;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // tx_data_q always holds active byte[idx_q] while in this state
                if (xfer) begin
                    acc_d = acc_q + tx_data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_SEQ;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            S_SEQ: begin
                if (xfer) begin
                    acc_d   = acc_q + seq_q;
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    csum_done = 1'b1;
                    seq_d     = seq_q + 8'd1;
                    idx_d     = '0;
                    acc_d     = '0;
                    if (pend_vld_q) begin
                        active_d   = pend_q;
                        pend_vld_d = 1'b0;
                        state_d    = S_PAYLOAD;
                    end else if (frame_load) begin
                        active_d = frame_in;
                        state_d  = S_PAYLOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A load on the final transfer with an empty pending slot went straight to active above
        if (frame_load && (state_q != S_IDLE) && !(csum_done && !pend_vld_q)) begin
            if (!pend_vld_q || csum_done) begin
                pend_d     = frame_in;
                pend_vld_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        tx_valid_d = (state_d != S_IDLE);
        busy_d     = (state_d != S_IDLE) || pend_vld_d;
        case (state_d)
            S_PAYLOAD: tx_data_d = active_d[{idx_d, 3'b000} +: 8];
            S_SEQ:     tx_data_d = seq_d;
            S_CSUM:    tx_data_d = acc_d;
            default:   tx_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            seq_q      <= '0;
            acc_q      <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            acc_q      <= acc_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule
